// File: rtl/mem_py_pkg.sv
// mem_py_pkg: shared constants and the table-generation function for mem_py.
// Provides the default width, the operand-width helper and mul_entry(), which
// computes the multiplication-table entry for a packed {a, b} address.
package mem_py_pkg;

  localparam int N_DEFAULT = 8;

  // Operand width for a given address/data width.
  function automatic int h_of(input int n);
    return n / 2;
  endfunction

  // Table entry for a packed address: upper half times lower half, unsigned.
  // Carried at 64 bits so one function serves every legal N; callers
  // truncate to N bits, which never loses information because an HxH
  // product always fits in 2H = N bits.
  function automatic logic [63:0] mul_entry(input logic [63:0] addr,
                                            input int n = N_DEFAULT);
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    mask = (64'd1 << h_of(n)) - 64'd1;
    a    = (addr >> h_of(n)) & mask;
    b    = addr & mask;
    return a * b;
  endfunction

endpackage

// File: rtl/mem_py_rom.sv
// mem_py_rom: combinational multiplication table, address -> product.
// Ports: address [N-1:0] in ({a, b}), product [N-1:0] out (a*b).
// No state; contents are fixed by N at elaboration.
module mem_py_rom
  import mem_py_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] address,
  output logic [N-1:0] product
);

  always_comb begin
    product = N'(mul_entry(64'(address), N));
  end

endmodule

// File: rtl/mem_py.sv
// mem_py: read-only multiplication-table memory with a registered output.
// Ports: clk, rst (sync, active-high), address [N-1:0] = {a, b}, read_en, ce,
// data [N-1:0] = a*b one clock after a qualified read, 0 otherwise.
module mem_py
  import mem_py_pkg::*;
#(
  parameter int N = N_DEFAULT  // must be even and >= 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] address,
  input  logic         read_en,
  input  logic         ce,
  output logic [N-1:0] data
);

  logic [N-1:0] rom_q;
  logic         rd;

  mem_py_rom #(.N(N)) u_rom (
    .address (address),
    .product (rom_q)
  );

  assign rd = ce && read_en;

  // Idle cycles load a constant zero rather than the ROM output, so an
  // undriven or unknown address while idle never reaches data.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (rd) begin
      data <= rom_q;
    end else begin
      data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_py.sv
module tb_mem_py;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address;
  logic       read_en;
  logic       ce;
  logic [7:0] data;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q;

  mem_py #(.N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .read_en (read_en),
    .ce      (ce),
    .data    (data)
  );

  always #5 clk = ~clk;

  // Reference: only the low 8 address bits matter; the high nibble times
  // the low nibble gives the product.
  function automatic logic [7:0] ref_mul(input int unsigned a);
    int unsigned lo;
    lo = a % 256;
    return 8'((lo / 16) * (lo % 16));
  endfunction

  // Drive one cycle's inputs, record what data must show after the edge,
  // then step to 1 time unit past the rising edge.
  task automatic cyc(input bit r, input bit c, input bit re, input int unsigned a);
    rst     = r;
    ce      = c;
    read_en = re;
    address = 8'(a);
    if (r)             exp_q = 8'h00;
    else if (c && re)  exp_q = ref_mul(a);
    else               exp_q = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; read_en = 1'b0; address = 8'h00;

    // Reset held for two edges with a live read request
    cyc(1, 1, 1, 'hFF); chk("reset_edge1", data, 8'h00);
    cyc(1, 1, 1, 'hFF); chk("reset_edge2", data, 8'h00);
    cyc(0, 0, 0, 'h00); chk("after_reset_idle", data, 8'h00);

    // Directed reads, with constant expectations
    cyc(0, 1, 1, 'h00); chk("rd_00", data, 8'h00);
    cyc(0, 1, 1, 'h35); chk("rd_35", data, 8'h0F);
    cyc(0, 1, 1, 'h9A); chk("rd_9A", data, 8'h5A);
    cyc(0, 1, 1, 'hFF); chk("rd_FF", data, 8'hE1);
    cyc(0, 1, 1, 'h1F); chk("rd_1F", data, 8'h0F);

    // Output is registered: changing inputs mid-cycle must not move data
    rst = 1'b0; ce = 1'b1; read_en = 1'b1; address = 8'hFF;
    #2;
    chk("no_comb_path", data, 8'h0F);

    // Enable qualification
    cyc(0, 1, 0, 'h77); chk("ce_only", data, 8'h00);
    cyc(0, 0, 1, 'h77); chk("re_only", data, 8'h00);
    cyc(0, 1, 1, 'h77); chk("ce_re_77", data, 8'h31);

    // Unknown address while idle must not leak
    rst = 1'b0; ce = 1'b0; read_en = 1'b1; address = 8'bx;
    @(posedge clk); #1;
    chk("idle_x_addr", data, 8'h00);

    // Back-to-back reads
    cyc(0, 1, 1, 'h23); chk("b2b_23", data, 8'h06);
    cyc(0, 1, 1, 'h44); chk("b2b_44", data, 8'h10);
    cyc(0, 1, 1, 'hF2); chk("b2b_F2", data, 8'h1E);

    // Reset during a read stream discards the read it coincides with
    cyc(0, 1, 1, 'h23); chk("stream_23", data, 8'h06);
    cyc(1, 1, 1, 'h88); chk("rst_mid_88", data, 8'h00);
    cyc(0, 1, 1, 'h88); chk("post_rst_88", data, 8'h40);

    // Aliasing spot check
    cyc(0, 1, 1, 'h135); chk("alias_135", data, 8'h0F);
    cyc(0, 1, 1, 'h100); chk("alias_100", data, 8'h00);

    // Pulse sweep: read of i, then idle at address 0
    for (int i = 0; i <= 'h10FF; i++) begin
      cyc(0, 1, 1, i); chk("pulse_rd", data, exp_q);
      cyc(0, 0, 0, 0); chk("pulse_idle", data, 8'h00);
    end

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
          $urandom_range(0, 'hFFFF));
      chk("random", data, exp_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
